fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter and control-flow stage of the 8-bit accumulator core. Holds the PC, latches the ALU's 1-bit flag into a flag register, and resolves conditional branches, unconditional jumps and halt through a 16-entry branch-target lookup table. Sits directly downstream of the ALU, which produces the flag, and upstream of instruction fetch, which consumes `pc`. Also owns the program start/done handshake with the testbench.

## Interface
- `PC_W`, 10, PC and branch-target width.
- `LUT_AW`, 4, branch-table index width (2**LUT_AW entries).
- `CNT_W`, 16, cycle-counter width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin the program at PC 0.
- `flag_in`  in  1  ALU flag output for the current instruction.
- `flag_we`  in  1  current instruction writes the flag (add, lsl, sub, cmp).
- `branch`  in  1  current instruction is a branch-if-flag.
- `jump`  in  1  current instruction is an unconditional jump.
- `halt`  in  1  current instruction is halt.
- `tgt_idx`  in  LUT_AW  branch-table index for `branch`/`jump`.
- `lut_we`  in  1  branch-table write enable.
- `lut_waddr`  in  LUT_AW  branch-table write address.
- `lut_wdata`  in  PC_W  branch-table write data.
- `pc`  out  PC_W  registered program counter.
- `flag_q`  out  1  registered flag.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HALTED.
- `cycles`  out  CNT_W  RUN cycles since the last start; saturating.

## Operation
- FSM states: IDLE, RUN, HALTED.
  - IDLE --start--> RUN.
  - RUN --halt--> HALTED.
  - HALTED --start--> RUN.
  - `start` in RUN is ignored.
- Start (IDLE or HALTED with `start`=1), next cycle:
  - `pc`=0, `flag_q`=0, `cycles`=0.
  - State is RUN.
- In RUN, next PC, highest priority first:
  - `halt`: pc holds.
  - `jump`: pc = LUT[tgt_idx].
  - `branch` && `flag_q`: pc = LUT[tgt_idx].
  - Otherwise: pc = pc+1, wrapping from 2**PC_W-1 to 0.
- Branch condition uses `flag_q`, the value before this edge. A same-cycle `flag_we` does not affect the current branch decision.
- Flag register:
  - In RUN with `flag_we`=1, `flag_q` ← `flag_in`.
  - Otherwise `flag_q` holds. It is sticky across taken branches and jumps.
- Outside RUN, `flag_we`, `branch`, `jump` and `halt` are ignored.
- Branch table:
  - `lut_we` writes in any state.
  - Read is combinational from the stored array. A read and a write to the same index in one cycle returns the old entry; the new entry is visible the next cycle.
- `cycles` increments every RUN cycle, including the halt cycle, and saturates at 2**CNT_W-1. It holds in IDLE and HALTED.

## Timing
- Reset values:
  - `pc`=0, `flag_q`=0, `running`=0, `done`=0, `cycles`=0.
  - State is IDLE.
  - All branch-table entries are 0.
- `reset` has priority over `start`, `lut_we` and all decode inputs.
- `reset` asserted mid-RUN or in HALTED returns every output to its reset value on the next edge.
- Latency:
  - Every PC update takes effect 1 cycle after the decode inputs are sampled.
  - `running` rises 1 cycle after `start`.
  - `done` rises 1 cycle after `halt`, and `running` falls in the same cycle.
- `done` stays high until the cycle after the next accepted `start`.
- `pc` at halt is the halt instruction's own address; it is not incremented.

## Test plan
- Reset then start: `reset`=1 for 2 cycles, then `start` pulse. Required: pc=0, running=1 one cycle after start. Ten idle RUN cycles give pc=10 and cycles=10.
- Conditional branch: LUT[3]=0x050. In RUN, `flag_we`=1, `flag_in`=1 at pc=4, then `branch`=1, `tgt_idx`=3 at pc=5. Required: pc=0x050. A repeat with `flag_in`=0 gives pc=6.
- Same-cycle flag write and branch: `flag_q`=0; `flag_we`=1, `flag_in`=1, `branch`=1 in one cycle. Required: branch not taken (pc+1), and `flag_q`=1 afterwards.
- Priority and wrap:
  - `halt`=1 and `jump`=1 together: pc holds and `done`=1 next cycle.
  - Separate run, pc=0x3FF with no control input: pc=0x000.
- LUT write/read collision: LUT[2]=0x010; in one cycle `lut_we` writes LUT[2]=0x020 and `jump`=1, `tgt_idx`=2. Required: pc=0x010. The next jump via index 2 gives pc=0x020.
- Restart and mid-run reset:
  - From HALTED with cycles=37, `start`. Required: next cycle pc=0, cycles=0, done=0, running=1.
  - Later `reset` mid-RUN. Required: all outputs 0 next cycle, and LUT entries read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program counter, flag register and control-flow resolution for the 8-bit accumulator core.
// Also owns the start/done handshake and a saturating count of RUN cycles.
module fetch_ctrl #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flag_in,
    input  logic              flag_we,
    input  logic              branch,
    input  logic              jump,
    input  logic              halt,
    input  logic [LUT_AW-1:0] tgt_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              flag_q,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  cycles
);

    localparam int LUT_N = 1 << LUT_AW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              flag_reg, flag_next;
    logic [CNT_W-1:0]  cycles_reg, cycles_next;

    logic [PC_W-1:0]   lut_mem [LUT_N];
    logic [LUT_N-1:0]  lut_entry_we;
    logic [PC_W-1:0]   lut_rdata;

    // Branch table: the table must come out of reset all-zero, so it lives in
    // registers rather than block RAM.
    generate
        for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut_we
            assign lut_entry_we[gi] = lut_we && (lut_waddr == LUT_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < LUT_N; i++) begin
            if (reset) begin
                lut_mem[i] <= '0;
            end else if (lut_entry_we[i]) begin
                lut_mem[i] <= lut_wdata;
            end
        end
    end

    // Reading the stored array means a same-cycle write is only seen next cycle.
    assign lut_rdata = lut_mem[tgt_idx];

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        flag_next   = flag_reg;
        cycles_next = cycles_reg;
        unique case (state_reg)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_next  = ST_RUN;
                    pc_next     = '0;
                    flag_next   = 1'b0;
                    cycles_next = '0;
                end
            end
            ST_RUN: begin
                if (cycles_reg != {CNT_W{1'b1}}) begin
                    cycles_next = cycles_reg + CNT_W'(1);
                end
                if (flag_we) begin
                    flag_next = flag_in;
                end
                // The branch decision uses the flag as it stood before this edge.
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (jump || (branch && flag_reg)) begin
                    pc_next = lut_rdata;
                end else begin
                    pc_next = pc_reg + PC_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            flag_reg   <= 1'b0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            flag_reg   <= flag_next;
            cycles_reg <= cycles_next;
        end
    end

    assign pc      = pc_reg;
    assign flag_q  = flag_reg;
    assign running = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_HALTED);
    assign cycles  = cycles_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random stimulus,
// all compared against a cycle-level behavioural model of the program-counter rules.
module tb_fetch_ctrl;

    localparam int PC_W    = 10;
    localparam int LUT_AW  = 4;
    localparam int CNT_W   = 8;
    localparam int LUT_N   = 1 << LUT_AW;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              flag_in = 1'b0;
    logic              flag_we = 1'b0;
    logic              branch = 1'b0;
    logic              jump = 1'b0;
    logic              halt = 1'b0;
    logic [LUT_AW-1:0] tgt_idx = '0;
    logic              lut_we = 1'b0;
    logic [LUT_AW-1:0] lut_waddr = '0;
    logic [PC_W-1:0]   lut_wdata = '0;
    logic [PC_W-1:0]   pc;
    logic              flag_q;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (plain integers, no FSM encoding)
    int m_pc;
    int m_flag;
    int m_running;
    int m_done;
    int m_cycles;
    int m_lut [LUT_N];

    fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flag_in   (flag_in),
        .flag_we   (flag_we),
        .branch    (branch),
        .jump      (jump),
        .halt      (halt),
        .tgt_idx   (tgt_idx),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .pc        (pc),
        .flag_q    (flag_q),
        .running   (running),
        .done      (done),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        int target;
        target = m_lut[tgt_idx];
        if (reset) begin
            m_pc = 0; m_flag = 0; m_running = 0; m_done = 0; m_cycles = 0;
            for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
            return;
        end
        if (!m_running && start) begin
            m_pc = 0; m_flag = 0; m_cycles = 0; m_running = 1; m_done = 0;
        end else if (m_running) begin
            m_cycles = (m_cycles < CNT_MAX) ? m_cycles + 1 : CNT_MAX;
            if (halt) begin
                m_running = 0;
                m_done = 1;
            end else if (jump || (branch && m_flag != 0)) begin
                m_pc = target;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
            if (flag_we) m_flag = int'(flag_in);
        end
        if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; flag_in = 0; flag_we = 0; branch = 0;
        jump = 0; halt = 0; tgt_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic lut_write(input int addr, input int data);
        lut_we = 1; lut_waddr = LUT_AW'(addr); lut_wdata = PC_W'(data);
        tick();
        lut_we = 0;
    endtask

    task automatic do_jump(input int idx);
        jump = 1; tgt_idx = LUT_AW'(idx);
        tick();
        jump = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_checks++;
        if ({pc, flag_q, running, done, cycles} !== '0)
            $display("FAIL reset_outputs: pc=%h flag=%b run=%b done=%b cyc=%0d required all 0",
                     pc, flag_q, running, done, cycles);
        else n_pass++;
    endtask

    task automatic test_start_run();
        start = 1;
        tick();
        start = 0;
        n_checks++;
        if (pc !== 10'd0 || running !== 1'b1 || done !== 1'b0 || cycles !== 8'd0)
            $display("FAIL start_entry: pc=%h run=%b done=%b cyc=%0d required pc=0 run=1 done=0 cyc=0",
                     pc, running, done, cycles);
        else n_pass++;
        repeat (10) tick();
        n_checks++;
        if (pc !== 10'd10 || cycles !== 8'd10 || pc !== PC_W'(m_pc))
            $display("FAIL ten_cycles: pc=%0d cyc=%0d required pc=10 cyc=10", pc, cycles);
        else n_pass++;
    endtask

    task automatic test_branch();
        lut_write(3, 'h050);
        lut_write(1, 4);
        do_jump(1);
        n_checks++;
        if (pc !== 10'd4) $display("FAIL jump_to_4: pc=%h required 004", pc);
        else n_pass++;
        flag_we = 1; flag_in = 1;
        tick();
        flag_we = 0; flag_in = 0;
        branch = 1; tgt_idx = 4'd3;
        tick();
        branch = 0;
        n_checks++;
        if (pc !== 10'h050 || flag_q !== 1'b1)
            $display("FAIL branch_taken: pc=%h flag=%b required pc=050 flag=1", pc, flag_q);
        else n_pass++;
        do_jump(1);
        flag_we = 1; flag_in = 0;
        tick();
        flag_we = 0;
        branch = 1; tgt_idx = 4'd3;
        tick();
        branch = 0;
        n_checks++;
        if (pc !== 10'd6 || flag_q !== 1'b0)
            $display("FAIL branch_not_taken: pc=%h flag=%b required pc=006 flag=0", pc, flag_q);
        else n_pass++;
    endtask

    task automatic test_same_cycle_flag();
        flag_we = 1; flag_in = 1; branch = 1; tgt_idx = 4'd3;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 10'd7 || flag_q !== 1'b1)
            $display("FAIL same_cycle_flag: pc=%h flag=%b required pc=007 flag=1", pc, flag_q);
        else n_pass++;
    endtask

    task automatic test_collision();
        lut_write(2, 'h010);
        lut_we = 1; lut_waddr = 4'd2; lut_wdata = 10'h020;
        jump = 1; tgt_idx = 4'd2;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== 10'h010) $display("FAIL lut_collision_old: pc=%h required 010", pc);
        else n_pass++;
        do_jump(2);
        n_checks++;
        if (pc !== 10'h020) $display("FAIL lut_collision_new: pc=%h required 020", pc);
        else n_pass++;
    endtask

    task automatic test_wrap();
        lut_write(5, 'h3FF);
        do_jump(5);
        n_checks++;
        if (pc !== 10'h3FF) $display("FAIL wrap_setup: pc=%h required 3ff", pc);
        else n_pass++;
        tick();
        n_checks++;
        if (pc !== 10'h000) $display("FAIL pc_wrap: pc=%h required 000", pc);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [PC_W-1:0]  pc_exp;
        logic             flag_exp;
        logic [CNT_W-1:0] cyc_exp;
        tick();
        tick();
        pc_exp = PC_W'(m_pc);
        halt = 1; jump = 1; branch = 1; tgt_idx = 4'd3;
        tick();
        clear_inputs();
        n_checks++;
        if (pc !== pc_exp || pc !== 10'd2 || done !== 1'b1 || running !== 1'b0)
            $display("FAIL halt_over_jump: pc=%h done=%b run=%b required pc=%h done=1 run=0",
                     pc, done, running, pc_exp);
        else n_pass++;
        flag_exp = m_flag[0];
        cyc_exp  = CNT_W'(m_cycles);
        jump = 1; branch = 1; flag_we = 1; flag_in = ~flag_exp; tgt_idx = 4'd5;
        repeat (3) tick();
        clear_inputs();
        n_checks++;
        if (pc !== pc_exp || flag_q !== flag_exp || cycles !== cyc_exp || done !== 1'b1)
            $display("FAIL halted_ignores_decode: pc=%h flag=%b cyc=%0d required pc=%h flag=%b cyc=%0d",
                     pc, flag_q, cycles, pc_exp, flag_exp, cyc_exp);
        else n_pass++;
    endtask

    task automatic test_restart();
        start = 1;
        tick();
        start = 0;
        repeat (36) tick();
        halt = 1;
        tick();
        halt = 0;
        n_checks++;
        if (cycles !== 8'd37 || done !== 1'b1 || pc !== 10'd36)
            $display("FAIL halt_count: cyc=%0d done=%b pc=%0d required cyc=37 done=1 pc=36",
                     cycles, done, pc);
        else n_pass++;
        start = 1;
        tick();
        start = 0;
        n_checks++;
        if (pc !== 10'd0 || cycles !== 8'd0 || done !== 1'b0 || running !== 1'b1)
            $display("FAIL restart: pc=%h cyc=%0d done=%b run=%b required pc=0 cyc=0 done=0 run=1",
                     pc, cycles, done, running);
        else n_pass++;
        repeat (3) tick();
        start = 1;
        tick();
        start = 0;
        n_checks++;
        if (pc !== 10'd4 || cycles !== 8'd4)
            $display("FAIL start_in_run: pc=%0d cyc=%0d required pc=4 cyc=4", pc, cycles);
        else n_pass++;
    endtask

    task automatic test_saturation();
        repeat (300) tick();
        n_checks++;
        if (cycles !== 8'hFF || pc !== PC_W'(m_pc))
            $display("FAIL cycles_saturate: cyc=%0d pc=%h required cyc=255 pc=%h",
                     cycles, pc, PC_W'(m_pc));
        else n_pass++;
        halt = 1;
        tick();
        halt = 0;
        n_checks++;
        if (cycles !== 8'hFF || done !== 1'b1)
            $display("FAIL saturate_at_halt: cyc=%0d done=%b required cyc=255 done=1", cycles, done);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 9) == 0);
            halt      = ($urandom_range(0, 29) == 0);
            jump      = ($urandom_range(0, 7) == 0);
            branch    = ($urandom_range(0, 3) == 0);
            flag_we   = ($urandom_range(0, 1) == 1);
            flag_in   = ($urandom_range(0, 1) == 1);
            tgt_idx   = LUT_AW'($urandom);
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = LUT_AW'($urandom);
            lut_wdata = PC_W'($urandom);
            tick();
            n_checks++;
            if (pc !== PC_W'(m_pc) || flag_q !== m_flag[0] || running !== m_running[0] ||
                done !== m_done[0] || cycles !== CNT_W'(m_cycles))
                $display("FAIL random_step%0d: pc=%h flag=%b run=%b done=%b cyc=%0d required pc=%h flag=%0d run=%0d done=%0d cyc=%0d",
                         n, pc, flag_q, running, done, cycles, PC_W'(m_pc), m_flag, m_running, m_done, m_cycles);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_midrun_reset();
        lut_write(7, 'h123);
        if (m_running == 0) begin
            start = 1;
            tick();
            start = 0;
        end
        flag_we = 1; flag_in = 1;
        repeat (5) tick();
        clear_inputs();
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if ({pc, flag_q, running, done, cycles} !== '0)
            $display("FAIL midrun_reset: pc=%h flag=%b run=%b done=%b cyc=%0d required all 0",
                     pc, flag_q, running, done, cycles);
        else n_pass++;
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < LUT_N; k++) begin
            do_jump(k);
            n_checks++;
            if (pc !== 10'd0) $display("FAIL lut_cleared_idx%0d: pc=%h required 000", k, pc);
            else n_pass++;
        end
    endtask

    initial begin
        m_pc = 0; m_flag = 0; m_running = 0; m_done = 0; m_cycles = 0;
        for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
        test_reset();
        test_start_run();
        test_branch();
        test_same_cycle_flag();
        test_collision();
        test_wrap();
        test_priority();
        test_restart();
        test_saturation();
        test_random();
        test_midrun_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
